mem_arbiter: RTL and testbench

Two-requester arbiter that shares one single-port, variable-latency memory between the pipeline's instruction-fetch port and its data-access port (DMType-encoded loads/stores). It serialises accesses, returns read data to the winner, and produces a freeze signal that holds the whole pipeline while an access is outstanding. Data requests have fixed priority over fetch, with a starvation guard.

---
 rtl/mem_arbiter_pkg.sv | 13 +
 rtl/mem_arbiter_if.sv | 43 ++++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_e;

    // Instruction fetches always move a full word; this reuses the pipeline's DMType word code.
    localparam logic [2:0] DMT_WORD = 3'b010;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the pipeline fetch/data ports, the arbiter and the shared memory.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;

    logic              d_req;
    logic              d_we;
    logic [2:0]        d_type;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;

    logic              m_en;
    logic              m_we;
    logic [2:0]        m_type;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    logic              m_ready;

    logic              stall;

    // Arbiter side: serves requests and drives the memory.
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_type, d_addr, d_wdata, m_rdata, m_ready,
        output if_rdata, if_valid, d_rdata, d_valid,
               m_en, m_we, m_type, m_addr, m_wdata, stall
    );

    // Environment side: pipeline requesters plus the memory.
    modport master (
        output if_req, if_addr, d_req, d_we, d_type, d_addr, d_wdata, m_rdata, m_ready,
        input  if_rdata, if_valid, d_rdata, d_valid,
               m_en, m_we, m_type, m_addr, m_wdata, stall
    );

endinterface

// File: rtl/mem_arbiter.sv
// Serialises fetch and data accesses onto one variable-latency memory port;
// data wins by default, fetch wins after STARVE_MAX consecutive losses.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ARB_IDLE   | no access outstanding; arbitrate eligible requests
// ARB_BUSY_I | fetch access on the memory, waiting for m_ready
// ARB_BUSY_D | data access on the memory, waiting for m_ready
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input logic           clk,
    input logic           reset,
    mem_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  starve_cnt;

    logic              if_valid_q, d_valid_q;
    logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
    logic              m_we_q;
    logic [2:0]        m_type_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [DATA_W-1:0] m_wdata_q;

    logic if_elig, d_elig;
    logic grant_i, grant_d, done;

    // A requester whose valid pulse is showing has just been served and must not be re-granted.
    assign if_elig = bus.if_req & ~if_valid_q;
    assign d_elig  = bus.d_req  & ~d_valid_q;

    always_comb begin
        state_d = state_q;
        grant_i = 1'b0;
        grant_d = 1'b0;
        done    = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (d_elig && ((starve_cnt < STARVE_LIM) || !if_elig)) begin
                    grant_d = 1'b1;
                    state_d = ARB_BUSY_D;
                end else if (if_elig) begin
                    grant_i = 1'b1;
                    state_d = ARB_BUSY_I;
                end
            end
            ARB_BUSY_I, ARB_BUSY_D: begin
                if (bus.m_ready) begin
                    done    = 1'b1;
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            m_we_q     <= 1'b0;
            m_type_q   <= '0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
        end else begin
            if_valid_q <= done && (state_q == ARB_BUSY_I);
            d_valid_q  <= done && (state_q == ARB_BUSY_D);

            if (grant_d) begin
                m_we_q    <= bus.d_we;
                m_type_q  <= bus.d_type;
                m_addr_q  <= bus.d_addr;
                m_wdata_q <= bus.d_wdata;
            end else if (grant_i) begin
                m_we_q   <= 1'b0;
                m_type_q <= DMT_WORD;
                m_addr_q <= bus.if_addr;
            end

            if (done && (state_q == ARB_BUSY_I)) begin
                if_rdata_q <= bus.m_rdata;
            end
            // Stores leave the load-data register untouched.
            if (done && (state_q == ARB_BUSY_D) && !m_we_q) begin
                d_rdata_q <= bus.m_rdata;
            end

            if (grant_i) begin
                starve_cnt <= '0;
            end else if (grant_d && if_elig && (starve_cnt < STARVE_LIM)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    assign bus.m_en     = (state_q != ARB_IDLE);
    assign bus.m_we     = m_we_q;
    assign bus.m_type   = m_type_q;
    assign bus.m_addr   = m_addr_q;
    assign bus.m_wdata  = m_wdata_q;
    assign bus.if_valid = if_valid_q;
    assign bus.d_valid  = d_valid_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.stall    = (bus.if_req & ~if_valid_q) | (bus.d_req & ~d_valid_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level reference model, per-cycle compare,
// plus hand-computed grant orders, pulse counts and data values.
module tb_mem_arbiter;

    localparam int STARVE_MAX = 4;

    logic clk;
    logic reset;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_s(input string name, input string act, input string exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // owner: 0 = memory free, 1 = fetch holds it, 2 = data holds it
    int          own = 0;
    int          losses = 0;
    logic        e_we = 1'b0;
    logic [2:0]  e_type = 3'b0;
    logic [31:0] e_addr = '0, e_wdata = '0, e_if_rdata = '0, e_d_rdata = '0;
    logic        e_if_valid = 1'b0, e_d_valid = 1'b0;
    logic        fe, de, nv_i, nv_d;
    string       glog = "";

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            own = 0; losses = 0;
            e_we = 1'b0; e_type = 3'b0; e_addr = '0; e_wdata = '0;
            e_if_rdata = '0; e_d_rdata = '0; e_if_valid = 1'b0; e_d_valid = 1'b0;
        end else begin
            nv_i = 1'b0;
            nv_d = 1'b0;
            if (own == 0) begin
                fe = bus.if_req && !e_if_valid;
                de = bus.d_req && !e_d_valid;
                if (de && (losses < STARVE_MAX || !fe)) begin
                    own = 2;
                    e_we = bus.d_we; e_type = bus.d_type;
                    e_addr = bus.d_addr; e_wdata = bus.d_wdata;
                    if (fe) losses = (losses + 1 > STARVE_MAX) ? STARVE_MAX : losses + 1;
                    glog = {glog, "D"};
                end else if (fe) begin
                    own = 1;
                    e_we = 1'b0; e_type = 3'b010; e_addr = bus.if_addr;
                    losses = 0;
                    glog = {glog, "I"};
                end
            end else if (bus.m_ready) begin
                if (own == 1) begin
                    e_if_rdata = bus.m_rdata;
                    nv_i = 1'b1;
                end else begin
                    if (!e_we) e_d_rdata = bus.m_rdata;
                    nv_d = 1'b1;
                end
                own = 0;
            end
            e_if_valid = nv_i;
            e_d_valid  = nv_d;
        end
    end

    always @(negedge clk) begin
        chk("m_en",     bus.m_en,     own != 0);
        chk("m_we",     bus.m_we,     e_we);
        chk("m_type",   bus.m_type,   e_type);
        chk("m_addr",   bus.m_addr,   e_addr);
        chk("m_wdata",  bus.m_wdata,  e_wdata);
        chk("if_valid", bus.if_valid, e_if_valid);
        chk("d_valid",  bus.d_valid,  e_d_valid);
        chk("if_rdata", bus.if_rdata, e_if_rdata);
        chk("d_rdata",  bus.d_rdata,  e_d_rdata);
        chk("stall",    bus.stall,
            (bus.if_req & ~e_if_valid) | (bus.d_req & ~e_d_valid));
    end

    // ---------------- requesters and memory responder ----------------
    logic if_want = 1'b0, if_mask = 1'b0, d_keep = 1'b0, stray = 1'b0;
    int   lat = 1, en_cnt = 0;
    int   n_if = 0, n_d = 0, n_men = 0, n_hold = 0;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return (a == 32'h100) ? 32'h00500093 : (a ^ 32'hA5A50000);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (bus.if_valid) begin
            n_if++;
            if_want = 1'b0;
        end
        if (bus.d_valid) begin
            n_d++;
            if (!d_keep) bus.d_req = 1'b0;
        end
        bus.if_req = if_want & ~(if_mask & bus.d_valid);
        if (bus.m_en) begin
            n_men++;
            en_cnt++;
            if (bus.m_we && bus.m_addr == 32'h20 && bus.m_wdata == 32'hDEADBEEF && bus.m_type == 3'b010)
                n_hold++;
            if (en_cnt >= lat) begin
                bus.m_ready = 1'b1;
                bus.m_rdata = rd_word(bus.m_addr);
            end else begin
                bus.m_ready = 1'b0;
                bus.m_rdata = 32'h0BAD0BAD;
            end
        end else begin
            en_cnt = 0;
            bus.m_ready = stray;
            bus.m_rdata = 32'h0BAD0BAD;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clr();
        n_if = 0; n_d = 0; n_men = 0; n_hold = 0;
        glog = "";
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_type = 3'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.m_ready = 1'b0; bus.m_rdata = 32'h0BAD0BAD;
        run(3);
        reset = 1'b1;
        chk("rst_m_en",     bus.m_en,     1'b0);
        chk("rst_if_valid", bus.if_valid, 1'b0);
        chk("rst_d_valid",  bus.d_valid,  1'b0);
        chk("rst_if_rdata", bus.if_rdata, 32'h0);
        chk("rst_d_rdata",  bus.d_rdata,  32'h0);
        chk("rst_m_addr",   bus.m_addr,   32'h0);
        chk("rst_stall",    bus.stall,    1'b0);
        run(2);

        // single fetch, memory ready in the first busy cycle
        clr(); lat = 1;
        bus.if_addr = 32'h100; if_want = 1'b1; bus.if_req = 1'b1;
        run(6);
        chk("fetch_if_pulses", n_if, 1);
        chk("fetch_men_cycles", n_men, 1);
        chk("fetch_rdata", bus.if_rdata, 32'h00500093);
        chk_s("fetch_grants", glog, "I");

        // store, memory ready after 3 cycles
        clr(); lat = 3;
        bus.d_we = 1'b1; bus.d_type = 3'b010; bus.d_addr = 32'h20; bus.d_wdata = 32'hDEADBEEF;
        bus.d_req = 1'b1;
        run(8);
        chk("store_d_pulses", n_d, 1);
        chk("store_men_cycles", n_men, 3);
        chk("store_held_cycles", n_hold, 3);
        chk("store_d_rdata", bus.d_rdata, 32'h0);
        chk_s("store_grants", glog, "D");

        // load
        clr(); lat = 1;
        bus.d_we = 1'b0; bus.d_type = 3'b100; bus.d_addr = 32'h44; bus.d_req = 1'b1;
        run(5);
        chk("load_d_pulses", n_d, 1);
        chk("load_d_rdata", bus.d_rdata, 32'hA5A50044);
        chk_s("load_grants", glog, "D");

        // starvation guard: data re-requests continuously; fetch only visible outside data valid cycles
        clr(); lat = 1;
        bus.d_we = 1'b0; bus.d_type = 3'b010; bus.d_addr = 32'h50;
        d_keep = 1'b1; bus.d_req = 1'b1;
        if_mask = 1'b1; bus.if_addr = 32'h108; if_want = 1'b1; bus.if_req = 1'b1;
        run(18);
        d_keep = 1'b0; if_mask = 1'b0;
        run(8);
        chk_s("starve_grants", glog.substr(0, 4), "DDDDI");
        chk("starve_if_pulses", n_if, 1);
        chk("starve_if_rdata", bus.if_rdata, 32'hA5A50108);

        // collision in IDLE: data first, fetch next, one pulse each
        clr(); lat = 2;
        bus.d_we = 1'b0; bus.d_type = 3'b000; bus.d_addr = 32'h48; bus.d_req = 1'b1;
        bus.if_addr = 32'h104; if_want = 1'b1; bus.if_req = 1'b1;
        run(12);
        chk_s("coll_grants", glog, "DI");
        chk("coll_d_pulses", n_d, 1);
        chk("coll_if_pulses", n_if, 1);
        chk("coll_men_cycles", n_men, 4);
        chk("coll_d_rdata", bus.d_rdata, 32'hA5A50048);
        chk("coll_if_rdata", bus.if_rdata, 32'hA5A50104);

        // stray m_ready while idle
        clr(); stray = 1'b1;
        run(4);
        chk("stray_pulses", n_if + n_d, 0);
        chk("stray_men_cycles", n_men, 0);
        stray = 1'b0;
        run(1);

        // async reset in the middle of a data access
        clr(); lat = 20;
        bus.d_we = 1'b0; bus.d_type = 3'b010; bus.d_addr = 32'h60; d_keep = 1'b1; bus.d_req = 1'b1;
        run(3);
        chk("arst_busy_before", bus.m_en, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("arst_m_en",     bus.m_en,    1'b0);
        chk("arst_m_addr",   bus.m_addr,  32'h0);
        chk("arst_m_type",   bus.m_type,  3'b0);
        chk("arst_m_wdata",  bus.m_wdata, 32'h0);
        chk("arst_d_rdata",  bus.d_rdata, 32'h0);
        chk("arst_if_rdata", bus.if_rdata, 32'h0);
        bus.d_req = 1'b0; d_keep = 1'b0;
        run(2);
        #2 reset = 1'b1;
        clr();
        run(6);
        chk("arst_after_pulses", n_if + n_d, 0);
        chk("arst_after_men", n_men, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
